// File: rtl/aer_multicore_event_merger_if.sv
// AER merger bus: per-core FIFO head side plus the registered next-layer output link.
// The master modport is the merger; the slave modport is the core array plus downstream link.
interface aer_multicore_event_merger_if #(
    parameter int CORE_NUM                 = 16,
    parameter int AER_OUT_CORE_WIDTH       = 8,
    parameter int AER_OUT_NEXT_LAYER_WIDTH = 12
);
    logic [CORE_NUM-1:0]                    core_en;
    logic [CORE_NUM-1:0]                    core_req;
    logic [CORE_NUM*AER_OUT_CORE_WIDTH-1:0] core_addr;
    logic [CORE_NUM-1:0]                    core_ack;
    logic                                   evt_req;
    logic [AER_OUT_NEXT_LAYER_WIDTH-1:0]    evt_addr;
    logic                                   evt_ack;
    logic                                   err_type;

    modport master (
        input  core_en, core_req, core_addr, evt_ack,
        output core_ack, evt_req, evt_addr, err_type
    );

    modport slave (
        output core_en, core_req, core_addr, evt_ack,
        input  core_ack, evt_req, evt_addr, err_type
    );
endinterface

// File: rtl/aer_multicore_event_merger.sv
// Round-robin AER merger with a timestep barrier across a CORE_W x CORE_H core array.
// Define AER_ARB_STATS_EN to add the stat_neur_cnt / stat_valid statistics outputs.
module aer_multicore_event_merger #(
    parameter int CORE_W                   = 4,
    parameter int CORE_H                   = 4,
    parameter int CORE_NUM                 = CORE_W * CORE_H,
    parameter int AER_OUT_CORE_WIDTH       = 8,
    parameter int AER_OUT_NEXT_LAYER_WIDTH = AER_OUT_CORE_WIDTH + $clog2(CORE_H) + $clog2(CORE_W),
    parameter int STAT_W                   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    aer_multicore_event_merger_if.master bus
`ifdef AER_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]            stat_neur_cnt,
    output logic                         stat_valid
`endif
);
    localparam int W     = AER_OUT_CORE_WIDTH;
    localparam int ROW_W = $clog2(CORE_H);
    localparam int COL_W = $clog2(CORE_W);
    localparam int PTR_W = $clog2(CORE_NUM);

    typedef enum logic [1:0] {IDLE, NEUR, TSTEP} state_e;

    state_e                              state_q, state_d;
    logic                                evt_req_q, evt_req_d;
    logic [AER_OUT_NEXT_LAYER_WIDTH-1:0] evt_addr_q, evt_addr_d;
    logic [PTR_W-1:0]                    rr_ptr_q, rr_ptr_d;

    logic [CORE_NUM-1:0] cand, parked, ack;
    logic                loadable, xfer, pick_found, barrier, err;
    int                  pick_idx, low_en;
    logic [W-1:0]        head;

    if (CORE_NUM != CORE_W * CORE_H || STAT_W < 1 ||
        AER_OUT_NEXT_LAYER_WIDTH != W + ROW_W + COL_W) begin : g_cfg_check
        $error("aer_multicore_event_merger: inconsistent parameters");
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        loadable   = !evt_req_q || bus.evt_ack;
        xfer       = evt_req_q && bus.evt_ack;
        pick_found = 1'b0;
        pick_idx   = 0;
        low_en     = 0;
        ack        = '0;
        err        = 1'b0;
        state_d    = state_q;
        evt_addr_d = evt_addr_q;
        rr_ptr_d   = rr_ptr_q;

        for (int i = 0; i < CORE_NUM; i++) begin
            cand[i]   = bus.core_en[i] && bus.core_req[i] && (bus.core_addr[i*W+W-2 +: 2] != 2'b01);
            parked[i] = bus.core_en[i] && bus.core_req[i] && (bus.core_addr[i*W+W-2 +: 2] == 2'b01);
        end
        for (int i = CORE_NUM - 1; i >= 0; i--) begin
            if (bus.core_en[i]) low_en = i;
        end

        // Search starts at rr_ptr and wraps, so the core served last is considered last.
        for (int k = 0; k < CORE_NUM; k++) begin
            if (!pick_found && cand[(int'(rr_ptr_q) + k) % CORE_NUM]) begin
                pick_found = 1'b1;
                pick_idx   = (int'(rr_ptr_q) + k) % CORE_NUM;
            end
        end
        head    = bus.core_addr[pick_idx*W +: W];
        barrier = loadable && !pick_found && (bus.core_en != '0) &&
                  ((bus.core_en & ~parked) == '0);

        if (xfer) state_d = IDLE;
        if (loadable && pick_found) begin
            ack[pick_idx] = 1'b1;
            rr_ptr_d      = (pick_idx == CORE_NUM - 1) ? '0 : PTR_W'(pick_idx + 1);
            if (head[W-1:W-2] == 2'b00) begin
                state_d    = NEUR;
                evt_addr_d = {2'b00, head[W-3:0], ROW_W'(pick_idx / CORE_W), COL_W'(pick_idx % CORE_W)};
            end else begin
                err = 1'b1;
            end
        end else if (barrier) begin
            ack        = bus.core_en;
            state_d    = TSTEP;
            evt_addr_d = {2'b01, bus.core_addr[low_en*W +: W-2], {(ROW_W + COL_W){1'b0}}};
        end
        evt_req_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q    <= IDLE;
            evt_req_q  <= 1'b0;
            evt_addr_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            evt_req_q  <= evt_req_d;
            evt_addr_q <= evt_addr_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Pops are suppressed while reset is held so no event is consumed and then lost.
    assign bus.core_ack = rst ? '0 : ack;
    assign bus.err_type = err && !rst;
    assign bus.evt_req  = evt_req_q;
    assign bus.evt_addr = evt_addr_q;

`ifdef AER_ARB_STATS_EN
    logic [STAT_W-1:0] live_cnt_q, live_cnt_d, stat_cnt_q, stat_cnt_d;
    logic              stat_valid_q, stat_valid_d;

    always_comb begin
        live_cnt_d   = live_cnt_q;
        stat_cnt_d   = stat_cnt_q;
        stat_valid_d = 1'b0;
        if (xfer && state_q == TSTEP) begin
            stat_cnt_d   = live_cnt_q;
            live_cnt_d   = '0;
            stat_valid_d = 1'b1;
        end else if (xfer && state_q == NEUR && live_cnt_q != '1) begin
            live_cnt_d = live_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_cnt_q   <= '0;
            stat_cnt_q   <= '0;
            stat_valid_q <= 1'b0;
        end else begin
            live_cnt_q   <= live_cnt_d;
            stat_cnt_q   <= stat_cnt_d;
            stat_valid_q <= stat_valid_d;
        end
    end

    assign stat_neur_cnt = stat_cnt_q;
    assign stat_valid    = stat_valid_q;
`endif
endmodule

// File: tb/tb_aer_multicore_event_merger.sv
// Bench for aer_multicore_event_merger: single-cycle vector table, hand sequences and
// randomized per-core FIFO traffic checked against a queue-based reference model.
module tb_aer_multicore_event_merger;
    localparam int CN = 16;
    localparam int CW = 4;
    localparam int W  = 8;
    localparam int OW = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aer_multicore_event_merger_if #(
        .CORE_NUM(CN), .AER_OUT_CORE_WIDTH(W), .AER_OUT_NEXT_LAYER_WIDTH(OW)
    ) bus ();

`ifdef AER_ARB_STATS_EN
    logic [15:0] stat_neur_cnt;
    logic        stat_valid;
`endif

    aer_multicore_event_merger #(
        .CORE_W(4), .CORE_H(4), .AER_OUT_CORE_WIDTH(W), .STAT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef AER_ARB_STATS_EN
        ,
        .stat_neur_cnt(stat_neur_cnt),
        .stat_valid(stat_valid)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    fifo [CN][$];
    logic [OW-1:0] xfer_log [$];
    logic [CN-1:0] multi_ack;
    int            err_cnt;

    // Reference model: content of the output register and the round-robin start point.
    bit            m_valid;
    logic [OW-1:0] m_addr;
    int            m_rr;
`ifdef AER_ARB_STATS_EN
    logic [15:0] m_live, m_stat, stat_seen;
    bit          m_stat_valid;
`endif

    typedef struct {
        string         name;
        logic [CN-1:0] en;
        logic [CN-1:0] req;
        logic [7:0]    all_head;
        int            ov_core;
        logic [7:0]    ov_head;
        logic [CN-1:0] exp_ack;
        bit            exp_err;
        bit            exp_req;
        logic [OW-1:0] exp_addr;
    } vec_t;
    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_heads();
        for (int i = 0; i < CN; i++) begin
            bus.core_req[i]         = (fifo[i].size() != 0);
            bus.core_addr[i*W +: W] = (fifo[i].size() != 0) ? fifo[i][0] : 8'h00;
        end
    endtask

    // Called at posedge+1; checks reset values while inputs stay as they were.
    task automatic reset_dut();
        rst = 1'b1;
        @(negedge clk);
        check("rst_evt_req", 32'(bus.evt_req), 0);
        check("rst_evt_addr", 32'(bus.evt_addr), 0);
        check("rst_core_ack", 32'(bus.core_ack), 0);
        check("rst_err_type", 32'(bus.err_type), 0);
`ifdef AER_ARB_STATS_EN
        check("rst_stat_cnt", 32'(stat_neur_cnt), 0);
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < CN; i++) fifo[i].delete();
        xfer_log.delete();
        drive_heads();
        bus.evt_ack = 1'b0;
        m_valid     = 1'b0;
        m_addr      = '0;
        m_rr        = 0;
        multi_ack   = '0;
        err_cnt     = 0;
`ifdef AER_ARB_STATS_EN
        m_live = '0; m_stat = '0; m_stat_valid = 1'b0; stat_seen = '0;
`endif
        rst = 1'b0;
    endtask

    // One clock cycle of FIFO-driven traffic, checked against the model. posedge+1 to posedge+1.
    task automatic tick(input bit ack_in);
        logic [CN-1:0] exp_ack;
        logic [OW-1:0] nxt;
        logic [7:0]    h;
        bit            exp_err, load, found, all_parked;
        int            c, pick, low;
        bus.evt_ack = ack_in;
        drive_heads();
        exp_ack = '0; exp_err = 1'b0; load = 1'b0; nxt = m_addr; found = 1'b0; pick = 0;
        if (!m_valid || ack_in) begin
            for (int k = 0; k < CN; k++) begin
                c = (m_rr + k) % CN;
                if (!found && bus.core_en[c] && fifo[c].size() != 0) begin
                    h = fifo[c][0];
                    if (h[7:6] != 2'b01) begin
                        found = 1'b1;
                        pick  = c;
                    end
                end
            end
            if (found) begin
                h             = fifo[pick][0];
                exp_ack[pick] = 1'b1;
                m_rr          = (pick + 1) % CN;
                if (h[7:6] == 2'b00) begin
                    load = 1'b1;
                    nxt  = {2'b00, h[5:0], 2'(pick / CW), 2'(pick % CW)};
                end else begin
                    exp_err = 1'b1;
                end
            end else if (bus.core_en != '0) begin
                all_parked = 1'b1;
                low        = -1;
                for (int i = 0; i < CN; i++) begin
                    if (bus.core_en[i]) begin
                        if (low < 0) low = i;
                        if (fifo[i].size() == 0) all_parked = 1'b0;
                        else begin
                            h = fifo[i][0];
                            if (h[7:6] != 2'b01) all_parked = 1'b0;
                        end
                    end
                end
                if (all_parked) begin
                    exp_ack = bus.core_en;
                    load    = 1'b1;
                    h       = fifo[low][0];
                    nxt     = {2'b01, h[5:0], 4'b0000};
                end
            end
        end

        @(negedge clk);
        check("evt_req", 32'(bus.evt_req), 32'(m_valid));
        if (m_valid) check("evt_addr", 32'(bus.evt_addr), 32'(m_addr));
        check("core_ack", 32'(bus.core_ack), 32'(exp_ack));
        check("err_type", 32'(bus.err_type), 32'(exp_err));
        if (bus.evt_req && ack_in) xfer_log.push_back(bus.evt_addr);
        if ($countones(bus.core_ack) > 1) multi_ack = bus.core_ack;
        if (bus.err_type) err_cnt++;
`ifdef AER_ARB_STATS_EN
        check("stat_valid", 32'(stat_valid), 32'(m_stat_valid));
        if (m_stat_valid) check("stat_neur_cnt", 32'(stat_neur_cnt), 32'(m_stat));
        if (stat_valid) stat_seen = stat_neur_cnt;
`endif

        @(posedge clk);
        #1;
        for (int i = 0; i < CN; i++) begin
            if (exp_ack[i]) void'(fifo[i].pop_front());
        end
`ifdef AER_ARB_STATS_EN
        m_stat_valid = 1'b0;
        if (m_valid && ack_in) begin
            if (m_addr[11:10] == 2'b01) begin
                m_stat = m_live; m_live = '0; m_stat_valid = 1'b1;
            end else if (m_live != 16'hFFFF) begin
                m_live = m_live + 16'd1;
            end
        end
`endif
        if (load) begin
            m_valid = 1'b1;
            m_addr  = nxt;
        end else if (m_valid && ack_in) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        logic [1:0] typ;
        logic [5:0] id;
        int         n;
        int         exp_order [$];

        rst = 1'b1;
        bus.core_en = '1; bus.core_req = '0; bus.core_addr = '0; bus.evt_ack = 1'b0;
        @(posedge clk);
        #1;

        //            name        en        req       all    ov  ovh    ack       err req addr
        vecs.push_back('{"single5",  16'hFFFF, 16'h0020, 8'h00, 5, 8'h2A, 16'h0020, 0, 1, 12'h2A5});
        vecs.push_back('{"reserved", 16'hFFFF, 16'h0004, 8'h00, 2, 8'h85, 16'h0004, 1, 0, 12'h000});
        vecs.push_back('{"bar_half", 16'h00FF, 16'h00FF, 8'h43, -1, 8'h00, 16'h00FF, 0, 1, 12'h430});
        vecs.push_back('{"neur_win", 16'hFFFF, 16'hFFFF, 8'h43, 9, 8'h05, 16'h0200, 0, 1, 12'h059});
        vecs.push_back('{"en_zero",  16'h0000, 16'hFFFF, 8'h01, -1, 8'h00, 16'h0000, 0, 0, 12'h000});
        vecs.push_back('{"rr_first", 16'hFFFF, 16'h8001, 8'h3F, -1, 8'h00, 16'h0001, 0, 1, 12'h3F0});
        vecs.push_back('{"dis_cand", 16'h0001, 16'h0003, 8'h47, 1, 8'h01, 16'h0001, 0, 1, 12'h470});
        vecs.push_back('{"not_park", 16'h0003, 16'h0001, 8'h47, -1, 8'h00, 16'h0000, 0, 0, 12'h000});
        vecs.push_back('{"low_id",   16'h00F0, 16'h00F0, 8'h47, 4, 8'h44, 16'h00F0, 0, 1, 12'h440});
        vecs.push_back('{"res_all",  16'hFFFF, 16'hFFFF, 8'h80, -1, 8'h00, 16'h0001, 1, 0, 12'h000});
        vecs.push_back('{"dis_only", 16'hFFFE, 16'h0001, 8'h11, -1, 8'h00, 16'h0000, 0, 0, 12'h000});
        vecs.push_back('{"last15",   16'hFFFF, 16'h8000, 8'h22, -1, 8'h00, 16'h8000, 0, 1, 12'h22F});

        for (int v = 0; v < vecs.size(); v++) begin
            reset_dut();
            bus.core_en  = vecs[v].en;
            bus.core_req = vecs[v].req;
            for (int i = 0; i < CN; i++)
                bus.core_addr[i*W +: W] = (i == vecs[v].ov_core) ? vecs[v].ov_head : vecs[v].all_head;
            bus.evt_ack = 1'b1;
            @(negedge clk);
            check({vecs[v].name, "_ack"}, 32'(bus.core_ack), 32'(vecs[v].exp_ack));
            check({vecs[v].name, "_err"}, 32'(bus.err_type), 32'(vecs[v].exp_err));
            @(posedge clk);
            #1;
            bus.core_req = '0;
            @(negedge clk);
            check({vecs[v].name, "_req"}, 32'(bus.evt_req), 32'(vecs[v].exp_req));
            check({vecs[v].name, "_addr"}, 32'(bus.evt_addr), 32'(vecs[v].exp_addr));
            @(posedge clk);
            #1;
        end

        // Round-robin across cores 0, 3, 7 with two events each.
        bus.core_en = '1;
        reset_dut();
        foreach (exp_order[i]) exp_order.delete();
        for (int e = 0; e < 2; e++) begin
            fifo[0].push_back(8'(e + 1));
            fifo[3].push_back(8'(e + 4));
            fifo[7].push_back(8'(e + 8));
        end
        for (int c = 0; c < 8; c++) tick(1'b1);
        exp_order = '{0, 3, 7, 0, 3, 7};
        check("rr_count", 32'(xfer_log.size()), 6);
        for (int k = 0; k < 6 && k < xfer_log.size(); k++)
            check("rr_order", 32'(xfer_log[k][3:0]), 32'(exp_order[k]));

        // Barrier held until core 9 drains its neuron events.
        reset_dut();
        for (int i = 0; i < CN; i++) if (i != 9) fifo[i].push_back(8'h43);
        fifo[9] = '{8'h01, 8'h02, 8'h03, 8'h43};
        for (int c = 0; c < 8; c++) tick(1'b1);
        check("bar_count", 32'(xfer_log.size()), 4);
        for (int k = 0; k < 3 && k < xfer_log.size(); k++)
            check("bar_pre_core9", 32'(xfer_log[k][3:0]), 9);
        if (xfer_log.size() > 3) check("bar_tstep", 32'(xfer_log[3]), 32'h430);
        check("bar_ack_all", 32'(multi_ack), 32'hFFFF);

        // Reserved head on core 2, then a normal neuron event from core 4.
        reset_dut();
        fifo[2].push_back(8'h85);
        fifo[4].push_back(8'h11);
        for (int c = 0; c < 4; c++) tick(1'b1);
        check("res_err_cnt", 32'(err_cnt), 1);
        check("res_count", 32'(xfer_log.size()), 1);
        if (xfer_log.size() > 0) check("res_next", 32'(xfer_log[0]), 32'h114);

        // Backpressure for 10 cycles with 3 events pending, then a timestep.
        reset_dut();
        fifo[1].push_back(8'h0A);
        fifo[5].push_back(8'h0B);
        fifo[10].push_back(8'h0C);
        for (int c = 0; c < 11; c++) tick(1'b0);
        check("bp_no_xfer", 32'(xfer_log.size()), 0);
        for (int c = 0; c < 3; c++) tick(1'b1);
        check("bp_three", 32'(xfer_log.size()), 3);
        exp_order = '{1, 5, 10};
        for (int k = 0; k < 3 && k < xfer_log.size(); k++)
            check("bp_order", 32'(xfer_log[k][3:0]), 32'(exp_order[k]));
        for (int i = 0; i < CN; i++) fifo[i].push_back(8'h40);
        for (int c = 0; c < 4; c++) tick(1'b1);
`ifdef AER_ARB_STATS_EN
        check("stat_three", 32'(stat_seen), 3);
`endif

        // Reset while an event is held and another core is requesting.
        reset_dut();
        fifo[0].push_back(8'h01);
        fifo[1].push_back(8'h02);
        tick(1'b0);
        tick(1'b0);
        reset_dut();
        for (int c = 0; c < 2; c++) tick(1'b1);

        // Randomized traffic; odd rounds end every enabled core on a timestep.
        for (int r = 0; r < 8; r++) begin
            bus.core_en = (r == 0) ? 16'hFFFF : (r == 1) ? 16'h0000 : 16'($urandom);
            reset_dut();
            for (int i = 0; i < CN; i++) begin
                n = $urandom_range(0, 5);
                for (int j = 0; j < n; j++) begin
                    case ($urandom_range(0, 9))
                        7, 8:    typ = 2'b01;
                        9:       typ = 2'($urandom_range(2, 3));
                        default: typ = 2'b00;
                    endcase
                    id = 6'($urandom);
                    fifo[i].push_back({typ, id});
                end
                if (r[0] && bus.core_en[i]) begin
                    id = 6'($urandom);
                    fifo[i].push_back({2'b01, id});
                end
            end
            for (int c = 0; c < 150; c++) tick($urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
